// File: rtl/alu_accum_ctrl_pkg.sv
// Shared opcode encodings, FSM state encodings and small helpers for the
// ALU command sequencer / accumulator.
package alu_accum_ctrl_pkg;

  localparam int unsigned OpWidth = 4;

  localparam logic [OpWidth-1:0] AluOpAdd  = 4'd0;
  localparam logic [OpWidth-1:0] AluOpSub  = 4'd1;
  localparam logic [OpWidth-1:0] AluOpMul  = 4'd2;
  localparam logic [OpWidth-1:0] AluOpDiv  = 4'd3;
  localparam logic [OpWidth-1:0] AluOpMod  = 4'd4;
  localparam logic [OpWidth-1:0] AluOpAnd  = 4'd5;
  localparam logic [OpWidth-1:0] AluOpOr   = 4'd6;
  localparam logic [OpWidth-1:0] AluOpXor  = 4'd7;
  localparam logic [OpWidth-1:0] AluOpNand = 4'd8;
  localparam logic [OpWidth-1:0] AluOpNor  = 4'd9;
  localparam logic [OpWidth-1:0] AluOpXnor = 4'd10;
  localparam logic [OpWidth-1:0] AluOpNot  = 4'd11;
  localparam logic [OpWidth-1:0] AluOpShl  = 4'd12;
  localparam logic [OpWidth-1:0] AluOpShr  = 4'd13;
  localparam logic [OpWidth-1:0] AluOpLoad = 4'd14;
  localparam logic [OpWidth-1:0] AluOpClr  = 4'd15;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StResp  = 2'd2;

  function automatic logic is_div_op(logic [OpWidth-1:0] op);
    return (op == AluOpDiv) || (op == AluOpMod);
  endfunction

endpackage

// File: rtl/alu_accum_ctrl_if.sv
// Command, response and ALU-side buses of the accumulator sequencer.
// slave = the sequencer; master = command source, response sink and ALU.
interface alu_accum_ctrl_if #(
  parameter int unsigned WIDTH = 16
);
  import alu_accum_ctrl_pkg::*;

  logic               cmd_valid;
  logic               cmd_ready;
  logic [OpWidth-1:0] cmd_op;
  logic [WIDTH-1:0]   cmd_operand;

  logic               rsp_valid;
  logic               rsp_ready;
  logic [WIDTH-1:0]   rsp_result;
  logic               rsp_error;

  logic [WIDTH-1:0]   alu_a;
  logic [WIDTH-1:0]   alu_b;
  logic [OpWidth-1:0] alu_op;
  logic [WIDTH-1:0]   alu_result;
  logic               alu_error;

  modport slave (
    input  cmd_valid, cmd_op, cmd_operand, rsp_ready, alu_result, alu_error,
    output cmd_ready, rsp_valid, rsp_result, rsp_error, alu_a, alu_b, alu_op
  );

  modport master (
    output cmd_valid, cmd_op, cmd_operand, rsp_ready, alu_result, alu_error,
    input  cmd_ready, rsp_valid, rsp_result, rsp_error, alu_a, alu_b, alu_op
  );

endinterface

// File: rtl/alu_accum_ctrl_settle_cnt.sv
// 4-bit load/decrement settle counter with a zero flag.
module alu_accum_ctrl_settle_cnt (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 4'd0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != 4'd0)) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  assign zero = (cnt_q == 4'd0);

endmodule

// File: rtl/alu_accum_ctrl.sv
// Multi-cycle command sequencer and accumulator wrapped around the 16-bit ALU.
// Optional build macro ALU_ACCUM_SAT_EN saturates acc on ADD/MUL/SUB errors.
module alu_accum_ctrl
  import alu_accum_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned SETTLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  alu_accum_ctrl_if.slave  bus,
  output logic [WIDTH-1:0] acc,
  output logic             err_sticky,
  output logic             busy
);

  localparam logic [3:0] SettleLoad = 4'(SETTLE - 1);

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]   alu_b_q;
  logic [OpWidth-1:0] alu_op_q;
  logic [WIDTH-1:0]   rsp_result_q;
  logic               rsp_error_q;
  logic               err_sticky_q;

  logic               accept;
  logic               capture;
  logic               cnt_zero;
  logic [WIDTH-1:0]   cap_acc;
  logic               cap_err;

  assign accept  = (state_q == StIdle) && bus.cmd_valid;
  assign capture = (state_q == StIssue) && cnt_zero;

  alu_accum_ctrl_settle_cnt u_settle_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val (SettleLoad),
    .dec      (state_q == StIssue),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (bus.cmd_valid) state_d = StIssue;
      StIssue: if (cnt_zero)      state_d = StResp;
      StResp:  if (bus.rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Value and error committed at the end of ISSUE.
  always_comb begin
    cap_acc = bus.alu_result;
    cap_err = bus.alu_error;
    if (alu_op_q == AluOpLoad) begin
      cap_acc = alu_b_q;
      cap_err = 1'b0;
    end else if (alu_op_q == AluOpClr) begin
      cap_acc = '0;
      cap_err = 1'b0;
    end else if (is_div_op(alu_op_q) && bus.alu_error) begin
      cap_acc = acc_q;
    end
`ifdef ALU_ACCUM_SAT_EN
    else if (bus.alu_error && ((alu_op_q == AluOpAdd) || (alu_op_q == AluOpMul))) begin
      cap_acc = '1;
    end else if (bus.alu_error && (alu_op_q == AluOpSub)) begin
      cap_acc = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      acc_q        <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= AluOpAdd;
      rsp_result_q <= '0;
      rsp_error_q  <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        alu_b_q  <= bus.cmd_operand;
        alu_op_q <= bus.cmd_op;
      end
      if (capture) begin
        acc_q        <= cap_acc;
        rsp_result_q <= cap_acc;
        rsp_error_q  <= cap_err;
        err_sticky_q <= (alu_op_q == AluOpClr) ? 1'b0 : (err_sticky_q | cap_err);
      end
    end
  end

  assign bus.cmd_ready  = (state_q == StIdle);
  assign bus.rsp_valid  = (state_q == StResp);
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_error  = rsp_error_q;
  assign bus.alu_a      = acc_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_op     = alu_op_q;

  assign acc        = acc_q;
  assign err_sticky = err_sticky_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_alu_accum_ctrl.sv
// Directed bench for alu_accum_ctrl with a behavioural ALU on the ALU bus.
// Honors ALU_ACCUM_SAT_EN for the saturating expectations.
module tb_alu_accum_ctrl;
  import alu_accum_ctrl_pkg::*;

  localparam int SETTLE = 3;

`ifdef ALU_ACCUM_SAT_EN
  localparam logic [15:0] ExpAddOvf = 16'hFFFF;
  localparam logic [15:0] ExpSubUnf = 16'h0000;
`else
  localparam logic [15:0] ExpAddOvf = 16'h0000;
  localparam logic [15:0] ExpSubUnf = 16'hFFFF;
`endif

  logic        clk;
  logic        reset;
  logic [15:0] acc_w;
  logic        err_sticky_w;
  logic        busy_w;
  int          errors;
  int          checks;
  int          cyc;

  alu_accum_ctrl_if #(.WIDTH(16)) bus ();

  alu_accum_ctrl #(
    .WIDTH  (16),
    .SETTLE (SETTLE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .acc        (acc_w),
    .err_sticky (err_sticky_w),
    .busy       (busy_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU.
  logic [16:0] sum;
  logic [31:0] prod;
  always_comb begin
    sum            = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
    prod           = {16'h0, bus.alu_a} * {16'h0, bus.alu_b};
    bus.alu_result = 16'h0;
    bus.alu_error  = 1'b0;
    case (bus.alu_op)
      AluOpAdd:  begin bus.alu_result = sum[15:0]; bus.alu_error = sum[16]; end
      AluOpSub:  begin bus.alu_result = bus.alu_a - bus.alu_b;
                       bus.alu_error = bus.alu_a < bus.alu_b; end
      AluOpMul:  begin bus.alu_result = prod[15:0]; bus.alu_error = |prod[31:16]; end
      AluOpDiv:  if (bus.alu_b == 16'h0) bus.alu_error = 1'b1;
                 else bus.alu_result = bus.alu_a / bus.alu_b;
      AluOpMod:  if (bus.alu_b == 16'h0) bus.alu_error = 1'b1;
                 else bus.alu_result = bus.alu_a % bus.alu_b;
      AluOpAnd:  bus.alu_result = bus.alu_a & bus.alu_b;
      AluOpOr:   bus.alu_result = bus.alu_a | bus.alu_b;
      AluOpXor:  bus.alu_result = bus.alu_a ^ bus.alu_b;
      AluOpNand: bus.alu_result = ~(bus.alu_a & bus.alu_b);
      AluOpNor:  bus.alu_result = ~(bus.alu_a | bus.alu_b);
      AluOpXnor: bus.alu_result = ~(bus.alu_a ^ bus.alu_b);
      AluOpNot:  bus.alu_result = ~bus.alu_a;
      AluOpShl:  bus.alu_result = bus.alu_a << bus.alu_b[3:0];
      AluOpShr:  bus.alu_result = bus.alu_a >> bus.alu_b[3:0];
      AluOpLoad: bus.alu_result = bus.alu_b;
      default:   bus.alu_result = 16'h0;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one command; lat = edges from accept edge until rsp_valid is seen.
  task automatic send(input logic [3:0] op, input logic [15:0] operand, output int lat);
    int n;
    n = 0;
    bus.cmd_op      = op;
    bus.cmd_operand = operand;
    bus.cmd_valid   = 1'b1;
    while (!bus.cmd_ready && n < 30) begin tick(); n++; end
    tick();
    bus.cmd_valid = 1'b0;
    lat = 0;
    while (!bus.rsp_valid && lat < 30) begin tick(); lat++; end
  endtask

  task automatic pop();
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          n;
    int          t_prev;
    logic        seen;
    logic [3:0]  s_op  [4];
    logic [15:0] s_opd [4];
    logic [15:0] s_res [4];
    logic        s_err [4];

    errors          = 0;
    checks          = 0;
    reset           = 1'b1;
    bus.cmd_valid   = 1'b0;
    bus.cmd_op      = 4'h0;
    bus.cmd_operand = 16'h0;
    bus.rsp_ready   = 1'b0;
    tick();
    tick();
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_acc", acc_w, 0);
    chk("rst_sticky", err_sticky_w, 0);
    chk("rst_busy", busy_w, 0);
    chk("rst_alu_op", bus.alu_op, 0);
    chk("rst_alu_b", bus.alu_b, 0);
    chk("rst_rsp_result", bus.rsp_result, 0);
    reset = 1'b0;
    tick();

    send(AluOpLoad, 16'h1234, lat);
    chk("load_latency", lat, SETTLE);
    chk("load_result", bus.rsp_result, 16'h1234);
    chk("load_error", bus.rsp_error, 0);
    chk("load_acc", acc_w, 16'h1234);
    chk("load_alu_a", bus.alu_a, 16'h1234);
    chk("load_busy", busy_w, 1);
    pop();
    chk("after_pop_ready", bus.cmd_ready, 1);

    send(AluOpLoad, 16'hFFFF, lat);
    pop();
    send(AluOpAdd, 16'h0001, lat);
    chk("add_ovf_result", bus.rsp_result, ExpAddOvf);
    chk("add_ovf_error", bus.rsp_error, 1);
    chk("add_ovf_sticky", err_sticky_w, 1);
    pop();

    send(AluOpLoad, 16'h0064, lat);
    pop();
    send(AluOpDiv, 16'h0000, lat);
    chk("div0_acc", acc_w, 16'h0064);
    chk("div0_result", bus.rsp_result, 16'h0064);
    chk("div0_error", bus.rsp_error, 1);
    pop();
    send(AluOpClr, 16'h5555, lat);
    chk("clr_acc", acc_w, 0);
    chk("clr_sticky", err_sticky_w, 0);
    chk("clr_error", bus.rsp_error, 0);
    pop();

    send(AluOpLoad, 16'h0003, lat);
    pop();
    send(AluOpShl, 16'h0004, lat);
    chk("shl_result", bus.rsp_result, 16'h0030);
    bus.cmd_op      = AluOpLoad;
    bus.cmd_operand = 16'hAAAA;
    bus.cmd_valid   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_rsp_valid", bus.rsp_valid, 1);
      chk("hold_rsp_result", bus.rsp_result, 16'h0030);
      chk("hold_cmd_ready", bus.cmd_ready, 0);
    end
    bus.cmd_valid = 1'b0;
    pop();
    chk("hold_no_accept_acc", acc_w, 16'h0030);
    chk("hold_no_accept_busy", busy_w, 0);

    // Reset during the second ISSUE cycle of a MUL.
    send(AluOpLoad, 16'h0005, lat);
    pop();
    bus.cmd_op      = AluOpMul;
    bus.cmd_operand = 16'h0007;
    bus.cmd_valid   = 1'b1;
    n = 0;
    while (!bus.cmd_ready && n < 30) begin tick(); n++; end
    tick();
    bus.cmd_valid = 1'b0;
    chk("mul_issue_busy", busy_w, 1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", busy_w, 0);
    chk("abort_cmd_ready", bus.cmd_ready, 1);
    chk("abort_acc", acc_w, 0);
    chk("abort_rsp_valid", bus.rsp_valid, 0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.rsp_valid) seen = 1'b1;
    end
    chk("abort_no_response", seen, 0);

    // Streaming with rsp_ready held high; acc starts at 0.
    s_op[0] = AluOpLoad; s_opd[0] = 16'h0010; s_res[0] = 16'h0010; s_err[0] = 1'b0;
    s_op[1] = AluOpAdd;  s_opd[1] = 16'h0005; s_res[1] = 16'h0015; s_err[1] = 1'b0;
    s_op[2] = AluOpMul;  s_opd[2] = 16'h0003; s_res[2] = 16'h003F; s_err[2] = 1'b0;
    s_op[3] = AluOpSub;  s_opd[3] = 16'h0040; s_res[3] = ExpSubUnf; s_err[3] = 1'b1;
    bus.rsp_ready = 1'b1;
    t_prev = 0;
    for (int k = 0; k < 4; k++) begin
      bus.cmd_op      = s_op[k];
      bus.cmd_operand = s_opd[k];
      bus.cmd_valid   = 1'b1;
      n = 0;
      while (!bus.cmd_ready && n < 30) begin tick(); n++; end
      if (k > 0) chk("stream_interval", cyc - t_prev, SETTLE + 2);
      t_prev = cyc;
      tick();
      n = 0;
      while (!bus.rsp_valid && n < 30) begin tick(); n++; end
      chk("stream_result", bus.rsp_result, s_res[k]);
      chk("stream_error", bus.rsp_error, s_err[k]);
      if (k == 3) bus.cmd_valid = 1'b0;
      tick();
    end
    bus.rsp_ready = 1'b0;
    chk("stream_sticky", err_sticky_w, 1);
    chk("stream_final_acc", acc_w, ExpSubUnf);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_accum_ctrl.md
Name: alu_accum_ctrl

Overview:
Multi-cycle command sequencer and accumulator that sits directly upstream and downstream of the 16-bit ALU datapath (adder, logic, shift, mul/div/mod units). It accepts one command per transaction over a valid/ready handshake and drives the accumulator and operand onto the ALU. After a programmable settle time it captures the ALU result and error into the accumulator. It then returns the result over a second valid/ready handshake and keeps a sticky error flag.

Parameters:
WIDTH, 16, data width of accumulator, operand and ALU buses
SETTLE, 1, cycles the ALU inputs are held before capture (legal 1..15)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command (high only in IDLE)
cmd_op  input  4  opcode (encodings in shared header)
cmd_operand  input  WIDTH  operand B; for SHL/SHR only bits [3:0] (shamt) are used
alu_a  output  WIDTH  operand A to ALU (current accumulator)
alu_b  output  WIDTH  registered operand B to ALU
alu_op  output  4  registered opcode to ALU select logic
alu_result  input  WIDTH  ALU result for alu_op
alu_error  input  1  ALU error (carry/borrow, mul overflow, divide-by-zero)
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_result  output  WIDTH  accumulator value after the command
rsp_error  output  1  error of this command
acc  output  WIDTH  live accumulator
err_sticky  output  1  OR of all errors since last CLR/reset
busy  output  1  high in ISSUE or RESP

Behaviour:
- Clock/reset: one clock, clk; reset is synchronous and active-high, port named reset.
- Reset values: state=IDLE, acc=0, alu_b=0, alu_op=0 (ADD), cmd_ready=1, rsp_valid=0, rsp_result=0, rsp_error=0, err_sticky=0, busy=0.
- Reset asserted mid-operation aborts the command: no capture, and any pending response is dropped.
- Opcodes: ADD 0, SUB 1, MUL 2, DIV 3, MOD 4, AND 5, OR 6, XOR 7, NAND 8, NOR 9, XNOR 10, NOT 11, SHL 12, SHR 13, LOAD 14, CLR 15.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready: register cmd_op to alu_op and cmd_operand to alu_b, load the settle counter with SETTLE-1, go to ISSUE.
- ISSUE: cmd_ready=0, alu_a=acc, and alu_b/alu_op are held stable. The counter decrements each cycle. In the cycle the counter reads 0, the capture happens at the next edge and the block goes to RESP.
- Capture rules:
  - LOAD: acc<=alu_b, error 0.
  - CLR: acc<=0, err_sticky<=0, error 0.
  - DIV/MOD with alu_error=1: acc unchanged, error 1.
  - All other ops: acc<=alu_result and error<=alu_error.
  - rsp_result<=new acc value; rsp_error<=error; err_sticky|=error, except on CLR.
- RESP: rsp_valid=1, and rsp_result/rsp_error are held stable. On rsp_ready go to IDLE, so cmd_ready rises the following cycle. Back-to-back throughput is SETTLE+2 cycles per command when rsp_ready is held high.
- Latency: accept edge to rsp_valid high is exactly SETTLE cycles.
- Error sources (ALU-defined): ADD carry out; SUB no-borrow indication of the ALU (error=1 when A<B); MUL product >16 bits; DIV/MOD B=0.
- Width: all arithmetic is modulo 2^WIDTH. No sign interpretation.
- cmd_valid is ignored outside IDLE. rsp_ready is ignored outside RESP.

Optional Feature:
ALU_ACCUM_SAT_EN.
- Defined: on ADD or MUL with alu_error=1, acc<=all ones; on SUB with alu_error=1, acc<=0. rsp_error and err_sticky still report the error.
- Undefined: acc takes the wrapped alu_result as above.

Decomposition:
- Shared header alu_defs.vh holds the opcode `defines (ALU_OP_ADD..ALU_OP_CLR), the opcode width and the FSM state encodings IDLE=0, ISSUE=1, RESP=2. The ALU top-level decode uses the same header.
- One natural sub-module: alu_settle_cnt, a 4-bit load/decrement counter with a zero flag.
- The accumulator uses the existing 16-bit register only if it gains a load enable. Otherwise the accumulator is a local register.

Test Plan:
- Reset, then LOAD 0x1234 -> rsp_result=0x1234, rsp_error=0, acc=0x1234, rsp_valid high exactly SETTLE cycles after the accept edge.
- acc=0xFFFF, ADD 0x0001 (ALU returns 0x0000, err 1) -> rsp_result=0x0000, rsp_error=1, err_sticky=1; with ALU_ACCUM_SAT_EN -> rsp_result=0xFFFF.
- acc=0x0064, DIV 0x0000 (err 1) -> acc stays 0x0064, rsp_error=1; then CLR -> acc=0, err_sticky=0.
- acc=0x0003, SHL operand 0x0004 -> 0x0030; hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_result stable, cmd_ready=0, and a second cmd_valid is not accepted.
- SETTLE=3, assert reset in the 2nd ISSUE cycle of MUL -> next cycle state IDLE, acc=0, rsp_valid=0, and no response is ever issued.
- Stream 4 commands with rsp_ready=1 -> one accept every SETTLE+2 cycles, with results matching a reference model.
